// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 master.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

  // funct3[1:0] size codes; 2'b11 is illegal
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane placement for stores, lane extraction for loads, alignment check.
module apb_lane_align
  import apb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] prdata_i,
  output logic [3:0]  pstrb_o,
  output logic [31:0] pwdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt    = {offset_i, 3'b000};
  assign pwdata_o = wdata_i << shamt;
  assign rshift   = prdata_i >> shamt;

  // Strobes, read mask and legality all follow the size code
  always_comb begin
    pstrb_o      = 4'b0000;
    rdata_o      = rshift;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_B: begin
        pstrb_o = 4'b0001 << offset_i;
        rdata_o = {24'h0, rshift[7:0]};
      end
      SZ_H: begin
        pstrb_o      = 4'b0011 << offset_i;
        rdata_o      = {16'h0, rshift[15:0]};
        misaligned_o = offset_i[0];
      end
      SZ_W: begin
        pstrb_o      = 4'b1111;
        misaligned_o = (offset_i != 2'b00);
      end
      default: begin
        rdata_o      = 32'h0;
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB4 master: request in, SETUP/ACCESS, aligned response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Value held during the last tolerated pready-low ACCESS cycle
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e      state_q, state_d;
  logic [31:0]     paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [3:0]      pstrb_q, pstrb_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [1:0]      size_q, size_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [1:0]  al_size, al_offset;
  logic [3:0]  al_pstrb;
  logic [31:0] al_pwdata, al_rdata;
  logic        al_misaligned;

  // In IDLE the aligner sees the incoming request; afterwards the latched one
  assign al_size   = (state_q == StIdle) ? req_funct3[1:0] : size_q;
  assign al_offset = (state_q == StIdle) ? req_addr[1:0]   : paddr_q[1:0];

  apb_lane_align u_lane_align (
    .size_i       (al_size),
    .offset_i     (al_offset),
    .wdata_i      (req_wdata),
    .prdata_i     (prdata),
    .pstrb_o      (al_pstrb),
    .pwdata_o     (al_pwdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_misaligned)
  );

  // Next-state, APB and response logic
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (al_misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d   = StSetup;
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            size_d    = req_funct3[1:0];
            pwdata_d  = req_write ? al_pwdata : 32'h0;
            pstrb_d   = req_write ? al_pstrb : 4'b0000;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        // pready takes priority over an expiring timeout
        if (pready) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0 : al_rdata;
          rsp_err_d   = pslverr;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      paddr_q     <= 32'h0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0;
      pstrb_q     <= 4'b0000;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      size_q      <= 2'b00;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: random requests, queue-based APB slave and checker.
module tb_apb_master;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        legal;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prd;
    logic        serr;
    int          wt;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  logic prev_psel = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: response and bus fields from the request and slave behaviour
  function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] prd,
                                 input logic serr, input int wt);
    exp_t e;
    int nb, off;
    logic [63:0] mask;
    off = int'(addr % 4);
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.legal = (f3[1:0] != 2'd3) && ((addr % nb) == 0);
    e.addr  = addr;
    e.wr    = wr;
    e.prd   = prd;
    e.serr  = serr;
    e.wt    = wt;
    e.pstrb = 4'b0000;
    e.pwdata = 32'h0;
    if (wr) begin
      e.pwdata = wdata << (8 * off);
      for (int i = 0; i < nb; i++) e.pstrb[off + i] = 1'b1;
    end
    mask = (64'd1 << (8 * nb)) - 64'd1;
    if (!e.legal) begin
      e.rdata = 32'h0; e.err = 1'b1; e.lat = 1;
    end else if (wt >= int'(TO)) begin
      e.rdata = 32'h0; e.err = 1'b1; e.lat = int'(TO) + 2;
    end else begin
      e.rdata = wr ? 32'h0 : 32'((64'(prd) >> (8 * off)) & mask);
      e.err = serr;
      e.lat = 3 + wt;
    end
    e.acc = 0;
    return e;
  endfunction

  // APB slave: completion timing and data come from the in-flight scoreboard entry
  initial begin
    int acnt = 0;
    forever begin
      @(negedge clk);
      if (psel === 1'b1 && penable === 1'b1 && exp_q.size() != 0) begin
        pready  = (acnt == exp_q[0].wt);
        prdata  = pready ? exp_q[0].prd : $urandom;
        pslverr = pready ? exp_q[0].serr : 1'($urandom);
        acnt++;
      end else begin
        acnt    = 0;
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end
  end

  // Monitor: bus-field and response checks against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (psel === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].legal) begin
          chk("psel_without_legal_req", 128'(psel), 128'(0));
        end else begin
          chk("apb_fields", 128'({paddr, pwrite, pwdata, pstrb}),
              128'({exp_q[0].addr, exp_q[0].wr, exp_q[0].pwdata, exp_q[0].pstrb}));
          chk("penable_phase", 128'(penable), 128'(prev_psel));
        end
      end
      if (rsp_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data_err", 128'({rsp_rdata, rsp_err}), 128'({e.rdata, e.err}));
          chk("rsp_latency", 128'(cyc - e.acc), 128'(e.lat));
          chk("psel_low_at_rsp", 128'({psel, penable}), 128'(0));
        end
      end
    end
    prev_psel = psel;
  end

  // Present a request, hold it until accepted, then record its expectation
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] prd, input logic serr,
                        input int wt);
    exp_t e;
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("req_ready_wait", 128'(req_ready), 128'(1));
      req_valid = 1'b0;
      return;
    end
    e = model(wr, f3, addr, wdata, prd, serr, wt);
    e.acc = cyc;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int wt, r;
    logic [31:0] a;
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 128'(req_ready), 128'(1));
    chk("reset_apb", 128'({psel, penable, pwrite, paddr, pwdata, pstrb}), 128'(0));
    chk("reset_rsp", 128'({rsp_valid, rsp_rdata, rsp_err}), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b100, 32'h203, 32'h0, 32'hA5000000, 1'b0, 1);
    do_req(1'b1, 3'b001, 32'h101, 32'h1234, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b0, 0);
    do_req(1'b0, 3'b001, 32'h002, 32'h0, 32'hBEEF1234, 1'b1, 5);
    do_req(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 1000);
    do_req(1'b0, 3'b010, 32'h304, 32'h0, 32'h01234567, 1'b0, 0);
    do_req(1'b1, 3'b010, 32'h308, 32'hCAFEF00D, 32'h0, 1'b1, int'(TO) - 1);
    do_req(1'b1, 3'b101, 32'h30E, 32'hFFFF5A5A, 32'h0, 1'b0, int'(TO));
    drain();

    // Reset pulsed during ACCESS aborts without a response
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b0, 1000);
    begin
      int n = 0;
      while (!(psel === 1'b1 && penable === 1'b1) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("reach_access", 128'({psel, penable}), 128'(2'b11));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_apb", 128'({psel, penable, rsp_valid}), 128'(0));
      chk("abort_ready", 128'(req_ready), 128'(1));
      void'(exp_q.pop_front());
      @(negedge clk);
      rst = 1'b0;
    end
    // Back-to-back zero-wait loads
    do_req(1'b0, 3'b010, 32'h500, 32'h0, 32'h11112222, 1'b0, 0);
    do_req(1'b0, 3'b010, 32'h504, 32'h0, 32'h33334444, 1'b0, 0);
    drain();

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      wt = (r < 7) ? int'($urandom_range(0, 3)) : (r == 7) ? int'(TO) - 1 :
           (r == 8) ? int'(TO) : 1000;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom, 1'($urandom), wt);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB4 master sitting directly downstream of the core datapath. It takes one memory or system request per transaction: address, store data and funct3 size code. It runs the APB SETUP/ACCESS protocol, including byte-lane placement and strobes, waits for `pready`, and returns lane-aligned read data plus an error flag. Sign extension of loads stays in the datapath; this block only zero-aligns the addressed bytes to bit 0.

## Interface
- `TIMEOUT`, 255: ACCESS cycles with `pready` low before forced error termination; 0 disables the timeout.
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept (high only in IDLE)
- `req_write`  in  1  1 = store, 0 = load/fetch
- `req_funct3`  in  3  RISC-V size code; [1:0]: 00 byte, 01 half, 10 word, 11 illegal
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  read data, addressed bytes shifted to bit 0, upper bytes zero
- `rsp_err`  out  1  qualified by `rsp_valid`
- `paddr`  out  32  APB address
- `psel`, `penable`, `pwrite`  out  1 each  APB control
- `pwdata`  out  32  APB write data
- `pstrb`  out  4  APB4 byte strobes
- `prdata`  in  32  APB read data
- `pready`, `pslverr`  in  1 each  APB completion/status

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `req_ready`=1. On `req_valid`, latch the request.
  - If legal: go to SETUP.
  - If illegal (size 11, half with addr[0]=1, word with addr[1:0]≠0): stay in IDLE and pulse `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 next cycle. No `psel` is asserted.
- SETUP: `psel`=1, `penable`=0. Always go to ACCESS after one cycle.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=1: sample `prdata`/`pslverr` and go to IDLE.
  - `pready`=0: increment the wait counter.
  - If the counter reaches `TIMEOUT` (and `TIMEOUT`≠0): go to IDLE with `rsp_err`=1 and `rsp_rdata`=0.
- `paddr` = `req_addr` unmodified. `pwrite` = `req_write`.
- Lane offset: o = addr[1:0].
  - Writes: `pwdata` = `req_wdata` << 8·o. `pstrb` = 0001<<o (byte), 0011<<o (half), 1111 (word).
  - Reads: `pstrb`=0000 and `pwdata`=0.
  - Read response: `prdata` >> 8·o, masked to 8/16/32 bits by size.
- Write responses: `rsp_rdata`=0. `rsp_err` = `pslverr`. `pslverr` is ignored unless `pready`=1.
- `funct3`[2] (unsigned load) does not affect this block.

## Timing
- All APB outputs and `rsp_*` are registered.
- APB outputs are stable from SETUP through the last ACCESS cycle.
- Zero-wait transaction:
  - request accepted at edge N
  - SETUP during cycle N+1
  - ACCESS during cycle N+2
  - `rsp_valid` during cycle N+3
  - Request-to-response latency is 3 cycles; each `pready`-low cycle adds 1.
- `rsp_valid` is high for exactly one cycle. `req_ready` is high in that same cycle, so back-to-back requests are legal.
- Misaligned request: `rsp_valid` pulse 1 cycle after acceptance.
- Reset values (after the reset edge): state IDLE, `req_ready`=1, and `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `rsp_valid`, `rsp_rdata`, `rsp_err` all 0. Wait counter is 0.
- `rst` mid-transaction: `psel`/`penable` drop at the next edge and no `rsp_valid` is produced for the aborted request.
- `req_valid` while not IDLE is ignored; the requester must hold it until `req_ready`.
- Timeout and `pready` in the same cycle: `pready` wins, giving a normal completion.
- Counter width: ceil(log2(`TIMEOUT`+1)). It clears on entry to SETUP.

## Structure
- Package `apb_pkg`: FSM state enum (IDLE/SETUP/ACCESS), size code constants (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10), and a `TIMEOUT_DEFAULT`=255 constant.
- Sub-module `apb_lane_align` (combinational) computes the following; the FSM and registers stay in `apb_master`:
  - `pstrb` and shifted `pwdata` from size, offset and wdata
  - aligned, masked read data from `prdata`, size and offset
  - the misalignment flag

## Test plan
- LW, addr 0x100, `prdata`=0xDEADBEEF, `pready`=1 in first ACCESS -> `psel` on cycles N+1..N+2, `penable` on N+2, `rsp_valid` at N+3, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `pstrb`=0000.
- SB, addr 0x203, wdata 0x000000A5 -> `pwdata`=0xA5000000, `pstrb`=1000, `pwrite`=1. LBU at 0x203 with `prdata`=0xA5000000 -> `rsp_rdata`=0x000000A5.
- SH at addr 0x101 -> no `psel` ever; `rsp_valid`=1, `rsp_err`=1 one cycle after acceptance. Same for LW at 0x102 and funct3=011.
- LH at 0x002, `pready` low 5 cycles, then high with `pslverr`=1, `prdata`=0xBEEF1234 -> `rsp_valid` 8 cycles after acceptance, `rsp_rdata`=0x0000BEEF, `rsp_err`=1.
- `TIMEOUT`=4, `pready` stuck low -> `psel` drops after 4 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0. A following LW is accepted and completes normally.
- `rst` pulsed during ACCESS -> `psel`/`penable`=0 at the next edge, no `rsp_valid`, `req_ready`=1. A back-to-back pair of zero-wait LWs -> second accepted on the first's `rsp_valid` cycle, with responses 3 cycles apart.
